// File: rtl/ua_pkg.sv
// rtl/ua_pkg.sv - shared constants and tx state encoding for the UART transmitter
package ua_pkg;
   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;
endpackage

// File: rtl/ua_tx_fifo.sv
// rtl/ua_tx_fifo.sv - synchronous circular byte buffer feeding the transmitter
module ua_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [3:0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   // A full FIFO refuses a push even when a pop frees a slot this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == 4'(DEPTH));
   assign empty   = (count == 4'd0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 4'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ua_transmitter.sv
// rtl/ua_transmitter.sv - 16x-oversampled UART transmitter with input FIFO
module ua_transmitter
   import ua_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] din_byte,
   input  logic       din_valid,
   output logic       din_rdy,
   output logic       ser_out,
   output logic       busy,
   output logic [3:0] fifo_count
);
   tx_state_t  state, state_nx;
   logic [3:0] sample_cnt, sample_nx;
   logic [2:0] bit_cnt, bit_nx;
   logic [7:0] shift_reg, shift_nx;
   logic       ser_nx;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       bit_end;

   ua_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (din_valid && din_rdy),
      .pop   (fifo_pop),
      .din   (din_byte),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign din_rdy = !fifo_full;
   assign busy    = (state != IDLE);
   assign bit_end = (sample_cnt == 4'(OVERSAMPLE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sample_cnt <= 4'd0;
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'd0;
         ser_out    <= 1'b1;
      end else begin
         state      <= state_nx;
         sample_cnt <= sample_nx;
         bit_cnt    <= bit_nx;
         shift_reg  <= shift_nx;
         ser_out    <= ser_nx;
      end
   end

   // Everything advances only on enable ticks; the sample counter wraps 15->0 at each bit edge.
   always_comb begin
      state_nx  = state;
      sample_nx = sample_cnt;
      bit_nx    = bit_cnt;
      shift_nx  = shift_reg;
      ser_nx    = ser_out;
      fifo_pop  = 1'b0;
      if (enable) begin
         sample_nx = sample_cnt + 4'd1;
         case (state)
            IDLE: begin
               sample_nx = 4'd0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_nx = fifo_dout;
                  ser_nx   = 1'b0;
                  state_nx = START;
               end
            end
            START: begin
               if (bit_end) begin
                  state_nx = DATA;
                  ser_nx   = shift_reg[0];
                  shift_nx = shift_reg >> 1;
                  bit_nx   = 3'd0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
                     state_nx = STOP;
                     ser_nx   = 1'b1;
                     bit_nx   = 3'd0;
                  end else begin
                     ser_nx   = shift_reg[0];
                     shift_nx = shift_reg >> 1;
                     bit_nx   = bit_cnt + 3'd1;
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (bit_cnt == 3'(STOP_BITS - 1)) begin
                     bit_nx = 3'd0;
                     // Chain straight into the next start bit so back-to-back frames have no gap.
                     if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_nx = fifo_dout;
                        ser_nx   = 1'b0;
                        state_nx = START;
                     end else begin
                        state_nx = IDLE;
                     end
                  end else begin
                     bit_nx = bit_cnt + 3'd1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ua_transmitter.sv
// tb/tb_ua_transmitter.sv - directed self-checking bench for ua_transmitter
module tb_ua_transmitter;
   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] din_byte, din_byte2;
   logic       din_valid, din_valid2;
   logic       din_rdy, ser_out, busy;
   logic       din_rdy2, ser_out2, busy2;
   logic [3:0] fifo_count, fifo_count2;

   int errors = 0;
   int checks = 0;
   int en_div = 0;
   int en_cnt = 0;
   logic line_a [0:1023];
   logic busy_a [0:1023];
   logic en_a   [0:1023];
   logic [7:0] q [5];
   logic [7:0] r [3];

   always #5 clk = ~clk;

   ua_transmitter #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .din_byte(din_byte), .din_valid(din_valid),
      .din_rdy(din_rdy), .ser_out(ser_out), .busy(busy), .fifo_count(fifo_count)
   );

   ua_transmitter #(.FIFO_DEPTH(2), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .din_byte(din_byte2), .din_valid(din_valid2),
      .din_rdy(din_rdy2), .ser_out(ser_out2), .busy(busy2), .fifo_count(fifo_count2)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      en_cnt++;
      if (en_div == 0) enable = 1'b0;
      else             enable = ((en_cnt % en_div) == 0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic capture(input int n, input bit sel);
      for (int i = 0; i < n; i++) begin
         line_a[i] = sel ? ser_out2 : ser_out;
         busy_a[i] = sel ? busy2 : busy;
         if (i < n - 1) begin
            en_a[i+1] = enable;
            tick();
         end
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k < 16)       return 1'b0;
      else if (k < 144) return b[(k - 16) / 16];
      else              return 1'b1;
   endfunction

   function automatic logic [159:0] exp_frame(input logic [7:0] b);
      logic [159:0] v;
      for (int k = 0; k < 160; k++) v[k] = exp_bit(b, k);
      return v;
   endfunction

   function automatic logic [159:0] got_frame(input int base, input int stride);
      logic [159:0] v;
      for (int k = 0; k < 160; k++) v[k] = line_a[base + k * stride];
      return v;
   endfunction

   function automatic logic [7:0] decode(input int base);
      logic [7:0] d;
      for (int j = 0; j < 8; j++) d[j] = line_a[base + 24 + 16 * j];
      return d;
   endfunction

   function automatic int busy_ones(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (busy_a[i] === 1'b1) c++;
      return c;
   endfunction

   initial begin
      int bad;
      int w;
      rst = 1'b1; enable = 1'b0; en_div = 0;
      din_valid = 1'b0; din_byte = 8'h00; din_valid2 = 1'b0; din_byte2 = 8'h00;
      tick(); tick();
      chk("rst_ser_out", ser_out, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_din_rdy", din_rdy, 1);
      rst = 1'b0;

      // single 0x55 frame, enable every cycle
      en_div = 1; enable = 1'b1;
      din_byte = 8'h55; din_valid = 1'b1; tick(); din_valid = 1'b0;
      chk("push_count", fifo_count, 1);
      chk("no_same_cycle_pop", ser_out, 1);
      tick();
      chk("pop_count", fifo_count, 0);
      chk("start_busy", busy, 1);
      capture(160, 0);
      chk_vec("frame_55", got_frame(0, 1), exp_frame(8'h55));
      chk("busy_160", busy_ones(160), 160);
      tick();
      chk("idle_busy_55", busy, 0);
      chk("idle_ser_55", ser_out, 1);

      // fill FIFO with enable off, drop 0x77 while full, including on the pop cycle
      en_div = 0; enable = 1'b0;
      din_valid = 1'b1;
      din_byte = 8'h00; tick();
      din_byte = 8'hFF; tick();
      din_byte = 8'hA5; tick();
      din_byte = 8'h3C; tick();
      chk("full_count", fifo_count, 4);
      chk("full_din_rdy", din_rdy, 0);
      din_byte = 8'h77; tick();
      chk("full_drop_count", fifo_count, 4);
      en_div = 1; enable = 1'b1; tick();
      din_valid = 1'b0;
      chk("full_pop_drop_count", fifo_count, 3);
      capture(640, 0);
      chk_vec("b2b_frame_00", got_frame(0, 1), exp_frame(8'h00));
      chk_vec("b2b_frame_ff", got_frame(160, 1), exp_frame(8'hFF));
      chk_vec("b2b_frame_a5", got_frame(320, 1), exp_frame(8'hA5));
      chk_vec("b2b_frame_3c", got_frame(480, 1), exp_frame(8'h3C));
      chk("b2b_busy_640", busy_ones(640), 640);
      tick();
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_idle_count", fifo_count, 0);

      // enable one cycle in four
      en_div = 4;
      din_byte = 8'h81; din_valid = 1'b1; tick(); din_valid = 1'b0;
      w = 0;
      while (ser_out !== 1'b0 && w < 40) begin tick(); w++; end
      chk("div4_start_seen", ser_out, 0);
      capture(640, 0);
      chk_vec("div4_frame_81", got_frame(0, 4), exp_frame(8'h81));
      bad = 0;
      for (int i = 1; i < 640; i++) if (line_a[i] !== line_a[i-1] && en_a[i] !== 1'b1) bad++;
      chk("div4_change_only_on_enable", bad, 0);
      chk("div4_busy_640", busy_ones(640), 640);
      tick();
      chk("div4_idle_busy", busy, 0);

      // reset mid-frame with two bytes queued
      en_div = 0; enable = 1'b0;
      din_valid = 1'b1;
      din_byte = 8'h11; tick();
      din_byte = 8'h22; tick();
      din_byte = 8'h33; tick();
      din_valid = 1'b0;
      en_div = 1; enable = 1'b1; tick();
      chk("abort_queued", fifo_count, 2);
      for (int i = 0; i < 69; i++) tick();
      chk("abort_pre_line", ser_out, 0);
      rst = 1'b1; din_byte = 8'h44; din_valid = 1'b1; tick();
      chk("abort_ser_out", ser_out, 1);
      chk("abort_busy", busy, 0);
      chk("abort_count", fifo_count, 0);
      chk("abort_din_rdy", din_rdy, 1);
      rst = 1'b0; din_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (ser_out !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0) bad++;
      end
      chk("abort_no_resume", bad, 0);

      // push while idle on non-enable cycles; start waits for first enable
      en_div = 0; enable = 1'b0;
      din_byte = 8'h3A; din_valid = 1'b1; tick(); din_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("noen_ser_out", ser_out, 1);
      chk("noen_busy", busy, 0);
      chk("noen_count", fifo_count, 1);
      en_div = 1; enable = 1'b1; tick();
      chk("noen_first_start", ser_out, 0);
      chk("noen_first_busy", busy, 1);
      for (int i = 0; i < 160; i++) tick();
      chk("noen_idle_after", busy, 0);

      // loopback with simultaneous push/pop at counts 1 and 3
      for (int i = 0; i < 5; i++) q[i] = 8'($urandom);
      en_div = 0; enable = 1'b0;
      din_byte = q[0]; din_valid = 1'b1; tick();
      en_div = 1; enable = 1'b1;
      din_byte = q[1]; tick(); din_valid = 1'b0;
      chk("pushpop_at_1", fifo_count, 1);
      for (int i = 0; i < 800; i++) begin
         line_a[i] = ser_out;
         if (i < 799) begin
            din_valid = (i == 2 || i == 4 || i == 159);
            din_byte  = (i == 2) ? q[2] : (i == 4) ? q[3] : q[4];
            tick();
            din_valid = 1'b0;
            if (i + 1 == 160) chk("pushpop_at_3", fifo_count, 3);
         end
      end
      for (int f = 0; f < 5; f++) begin
         chk("loop_byte", decode(160 * f), q[f]);
         chk("loop_start_stop", {line_a[160*f+8], line_a[160*f+152]}, 2'b01);
      end
      tick();
      chk("loop_idle_busy", busy, 0);

      // two stop bits, depth 2
      r[0] = 8'($urandom); r[1] = 8'($urandom); r[2] = 8'hE7;
      en_div = 0; enable = 1'b0;
      din_valid2 = 1'b1;
      din_byte2 = r[0]; tick();
      din_byte2 = r[1]; tick();
      chk("sb2_din_rdy_full", din_rdy2, 0);
      din_byte2 = r[2]; tick();
      din_valid2 = 1'b0;
      chk("sb2_full_count", fifo_count2, 2);
      en_div = 1; enable = 1'b1; tick();
      chk("sb2_start_busy", busy2, 1);
      capture(352, 1);
      for (int f = 0; f < 2; f++) begin
         chk("sb2_byte", decode(176 * f), r[f]);
         chk("sb2_start_stop", {line_a[176*f+8], line_a[176*f+152], line_a[176*f+168]}, 3'b011);
      end
      chk("sb2_busy_352", busy_ones(352), 352);
      tick();
      chk("sb2_idle_busy", busy2, 0);
      chk("sb2_idle_ser", ser_out2, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
